// File: rtl/cache_controller_if.sv
//==============================================================================
// Module      : cache_controller_if
// Description : Pipeline-side and SRAM-side bus bundle for the cache controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface cache_controller_if;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ready;

    modport slave (
        input  MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
        output rdata, ready, sram_rd_en, sram_wr_en, sram_address, sram_wdata
    );

    modport master (
        output MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
        input  rdata, ready, sram_rd_en, sram_wr_en, sram_address, sram_wdata
    );
endinterface

`default_nettype wire

// File: rtl/cache_controller.sv
//==============================================================================
// Module      : cache_controller
// Description : 2-way set-associative, write-through / no-write-allocate cache
//               sitting between the MEM stage and an SRAM controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cache_controller #(
    parameter int SETS  = 64,
    parameter int TAG_W = 10
) (
    input  wire logic         clk,
    input  wire logic         rst,
    cache_controller_if.slave bus
);

    localparam int IDX_W = $clog2(SETS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0][SETS-1:0] valid_q;
    logic [SETS-1:0]      lru_q;
    logic [TAG_W-1:0]     tag_q  [2][SETS];
    logic [31:0]          data_q [2][SETS];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit0, w_hit1, w_hit, w_hit_way;
    logic [31:0]      w_hit_data;

    logic             w_ready, w_rd_en, w_wr_en;
    logic [31:0]      w_rdata;
    logic             w_line_wr, w_line_fill, w_line_way, w_lru_upd;
    logic [31:0]      w_line_data;
    logic             w_unused_addr;

    assign w_idx = bus.address[2 +: IDX_W];
    assign w_tag = bus.address[8 +: TAG_W];
    assign w_unused_addr = ^{bus.address[31:8+TAG_W], bus.address[1:0]};

    assign w_hit0     = valid_q[0][w_idx] && (tag_q[0][w_idx] == w_tag);
    assign w_hit1     = valid_q[1][w_idx] && (tag_q[1][w_idx] == w_tag);
    assign w_hit      = w_hit0 || w_hit1;
    assign w_hit_way  = w_hit1;
    assign w_hit_data = w_hit1 ? data_q[1][w_idx] : data_q[0][w_idx];

    always_comb begin
        state_d     = state_q;
        w_ready     = 1'b0;
        w_rdata     = 32'd0;
        w_rd_en     = 1'b0;
        w_wr_en     = 1'b0;
        w_line_wr   = 1'b0;
        w_line_fill = 1'b0;
        w_line_way  = w_hit_way;
        w_line_data = bus.wdata;
        w_lru_upd   = 1'b0;
        case (state_q)
            IDLE: begin
                // A simultaneous load+store request is handled as a store.
                if (bus.MEM_W_EN) begin
                    state_d = WRITE;
                end else if (bus.MEM_R_EN) begin
                    if (w_hit) begin
                        w_ready   = 1'b1;
                        w_rdata   = w_hit_data;
                        w_lru_upd = 1'b1;
                    end else begin
                        state_d = READ_MISS;
                    end
                end else begin
                    w_ready = 1'b1;
                end
            end
            READ_MISS: begin
                w_rd_en = 1'b1;
                if (bus.sram_ready) begin
                    w_ready     = 1'b1;
                    w_rdata     = bus.sram_rdata;
                    w_line_way  = lru_q[w_idx];
                    w_line_wr   = 1'b1;
                    w_line_fill = 1'b1;
                    w_line_data = bus.sram_rdata;
                    w_lru_upd   = 1'b1;
                    state_d     = IDLE;
                end
            end
            WRITE: begin
                w_wr_en = 1'b1;
                if (bus.sram_ready) begin
                    w_ready = 1'b1;
                    state_d = IDLE;
                    if (w_hit) begin
                        w_line_wr = 1'b1;
                        w_lru_upd = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset wins over any coincident fill or store update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            lru_q   <= '0;
        end else begin
            state_q <= state_d;
            if (w_line_wr) begin
                data_q[w_line_way][w_idx] <= w_line_data;
            end
            if (w_line_fill) begin
                valid_q[w_line_way][w_idx] <= 1'b1;
                tag_q[w_line_way][w_idx]   <= w_tag;
            end
            if (w_lru_upd) begin
                lru_q[w_idx] <= ~w_line_way;
            end
        end
    end

    assign bus.ready        = w_ready;
    assign bus.rdata        = w_rdata;
    assign bus.sram_rd_en   = w_rd_en;
    assign bus.sram_wr_en   = w_wr_en;
    assign bus.sram_address = bus.address;
    assign bus.sram_wdata   = bus.wdata;

endmodule

`default_nettype wire

// File: tb/tb_cache_controller.sv
//==============================================================================
// Module      : tb_cache_controller
// Description : Directed self-checking bench for cache_controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cache_controller;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    cache_controller_if bus ();

    cache_controller #(
        .SETS  (64),
        .TAG_W (10)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1. Drives one request and walks it to completion,
    // raising sram_ready in the lat-th cycle after leaving IDLE.
    task automatic access(input string tag, input bit is_rd, input bit is_wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input bit exp_hit, input int lat,
                          input logic [31:0] sdata, input logic [31:0] exp_rdata);
        bus.MEM_R_EN = is_rd;
        bus.MEM_W_EN = is_wr;
        bus.address  = addr;
        bus.wdata    = wd;
        #4;
        if (!is_wr && exp_hit) begin
            check_value({tag, ".hit_ready"}, bus.ready, 1);
            check_value({tag, ".hit_rdata"}, bus.rdata, exp_rdata);
            check_value({tag, ".hit_no_rd"}, bus.sram_rd_en, 0);
        end else begin
            check_value({tag, ".idle_ready"}, bus.ready, 0);
            for (int k = 0; k < lat; k++) begin
                @(posedge clk);
                #1;
                if (k == lat - 1) begin
                    bus.sram_ready = 1'b1;
                    bus.sram_rdata = sdata;
                end
                #3;
                check_value({tag, ".rd_en"}, bus.sram_rd_en, is_wr ? 0 : 1);
                check_value({tag, ".wr_en"}, bus.sram_wr_en, is_wr ? 1 : 0);
                check_value({tag, ".sram_addr"}, bus.sram_address, addr);
                if (is_wr) check_value({tag, ".sram_wdata"}, bus.sram_wdata, wd);
                check_value({tag, ".ready"}, bus.ready, (k == lat - 1) ? 1 : 0);
                if (!is_wr && k == lat - 1) check_value({tag, ".rdata"}, bus.rdata, exp_rdata);
            end
        end
        @(posedge clk);
        #1;
        bus.sram_ready = 1'b0;
        bus.MEM_R_EN   = 1'b0;
        bus.MEM_W_EN   = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.MEM_R_EN   = 1'b0;
        bus.MEM_W_EN   = 1'b0;
        bus.address    = 32'd0;
        bus.wdata      = 32'd0;
        bus.sram_rdata = 32'd0;
        bus.sram_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #4;
        check_value("rst.ready", bus.ready, 1);
        check_value("rst.rd_en", bus.sram_rd_en, 0);
        check_value("rst.wr_en", bus.sram_wr_en, 0);
        check_value("rst.rdata", bus.rdata, 0);
        // sram_ready while idle must be ignored
        bus.sram_ready = 1'b1;
        #1;
        check_value("idle_sram_ready.ready", bus.ready, 1);
        check_value("idle_sram_ready.rdata", bus.rdata, 0);
        @(posedge clk);
        #1;
        bus.sram_ready = 1'b0;

        // set 0 holds tags 0x4 / 0x8 / 0xC
        access("rd400_miss", 1, 0, 32'h400, 0, 0, 5, 32'hDEADBEEF, 32'hDEADBEEF);
        access("rd400_hit",  1, 0, 32'h400, 0, 1, 0, 0, 32'hDEADBEEF);
        access("rd800_miss", 1, 0, 32'h800, 0, 0, 2, 32'h08080808, 32'h08080808);
        access("rd400_hit2", 1, 0, 32'h400, 0, 1, 0, 0, 32'hDEADBEEF);
        access("rdC00_miss", 1, 0, 32'hC00, 0, 0, 2, 32'h0C0C0C0C, 32'h0C0C0C0C);
        access("rd400_hit3", 1, 0, 32'h400, 0, 1, 0, 0, 32'hDEADBEEF);
        access("rdC00_hit",  1, 0, 32'hC00, 0, 1, 0, 0, 32'h0C0C0C0C);

        access("wr400_hit",  0, 1, 32'h400, 32'h12345678, 0, 3, 0, 0);
        access("rd400_new",  1, 0, 32'h400, 0, 1, 0, 0, 32'h12345678);

        access("wr404_miss", 0, 1, 32'h404, 32'hAAAA5555, 0, 2, 0, 0);
        access("rd404_miss", 1, 0, 32'h404, 0, 0, 1, 32'h44444444, 32'h44444444);
        access("rd404_hit",  1, 0, 32'h404, 0, 1, 0, 0, 32'h44444444);

        access("rdwr408",    1, 1, 32'h408, 32'h0BADF00D, 0, 2, 0, 0);
        access("rd408_miss", 1, 0, 32'h408, 0, 0, 1, 32'h40804080, 32'h40804080);

        access("rd800_evicted", 1, 0, 32'h800, 0, 0, 2, 32'h08000800, 32'h08000800);
        access("rd400_kept",    1, 0, 32'h400, 0, 1, 0, 0, 32'h12345678);

        // reset coincident with sram_ready during a read miss
        bus.MEM_R_EN = 1'b1;
        bus.address  = 32'hA00;
        #4;
        check_value("rstmiss.idle_ready", bus.ready, 0);
        @(posedge clk);
        #1;
        bus.sram_ready = 1'b1;
        bus.sram_rdata = 32'h5A5A5A5A;
        rst            = 1'b1;
        #3;
        check_value("rstmiss.rd_en", bus.sram_rd_en, 1);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.sram_ready = 1'b0;
        bus.MEM_R_EN   = 1'b0;
        #3;
        check_value("rstmiss.rd_en_after", bus.sram_rd_en, 0);
        check_value("rstmiss.wr_en_after", bus.sram_wr_en, 0);
        check_value("rstmiss.ready_after", bus.ready, 1);
        @(posedge clk);
        #1;
        access("rdA00_nofill", 1, 0, 32'hA00, 0, 0, 1, 32'h00A000A0, 32'h00A000A0);
        access("rd400_cleared", 1, 0, 32'h400, 0, 0, 1, 32'h11111111, 32'h11111111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
